// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU op codes, RV32I opcode and funct constants,
// and the issue-entry bundle that is held in the main and skid registers.
// Every entry field is carried together, so one register load moves one whole instruction.
package alu_pkg;

  // Width of the operand fields in the stored entry; the stage's XLEN must match it.
  localparam int unsigned ENTRY_XLEN = 32;

  // ALU operation encodings consumed by the downstream ALU.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // RV32I major opcodes handled by this stage.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 / funct7 values.
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // Occupancy of the two-entry buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // One decoded, operand-resolved instruction ready for the ALU.
  typedef struct packed {
    logic [3:0]            alu_op;
    logic [ENTRY_XLEN-1:0] op1;
    logic [ENTRY_XLEN-1:0] op2;
    logic [4:0]            rd;
    logic                  rd_we;
    logic                  illegal;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_RESET = '{
    alu_op:  ALU_ADD,
    op1:     '0,
    op2:     '0,
    rd:      5'd0,
    rd_we:   1'b0,
    illegal: 1'b0
  };

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake bundle around the issue stage: fetch/regfile side in, ALU side out.
// The stage takes the slave view; the surrounding pipeline (or bench) takes the master view.
// rs1_addr/rs2_addr travel back to the regfile in the same cycle as the instruction.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      ALUop;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      rd;
  logic            rd_we;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr,
    output out_valid, ALUop, op1, op2, rd, rd_we, illegal
  );

  modport master (
    output in_valid, in_instr, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr,
    input  out_valid, ALUop, op1, op2, rd, rd_we, illegal
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational RV32I decode: ALU op, immediate and its selection, register fields, writeback enable.
// Zero latency; no state.
// No handshake of its own; the issue stage decides when the result is captured.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [3:0]      alu_op_o,
  output logic            use_imm_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;

  assign opcode     = instr_i[6:0];
  assign funct3     = instr_i[14:12];
  assign funct7     = instr_i[31:25];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];
  assign rd_o       = instr_i[11:7];
  assign imm_i      = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s      = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};

  // Classify the instruction; anything unrecognised falls through as an illegal ADD with no writeback.
  always_comb begin
    alu_op_o  = ALU_ADD;
    use_imm_o = 1'b0;
    imm_o     = imm_i;
    rd_we_o   = 1'b0;
    illegal_o = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) begin
          alu_op_o = ALU_ADD; rd_we_o = 1'b1; illegal_o = 1'b0;
        end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
          alu_op_o = ALU_SUB; rd_we_o = 1'b1; illegal_o = 1'b0;
        end else if (funct3 == F3_OR) begin
          alu_op_o = ALU_OR;  rd_we_o = 1'b1; illegal_o = 1'b0;
        end else if (funct3 == F3_AND) begin
          alu_op_o = ALU_AND; rd_we_o = 1'b1; illegal_o = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_ADD) begin
          alu_op_o = ALU_ADD; use_imm_o = 1'b1; rd_we_o = 1'b1; illegal_o = 1'b0;
        end else if (funct3 == F3_OR) begin
          alu_op_o = ALU_OR;  use_imm_o = 1'b1; rd_we_o = 1'b1; illegal_o = 1'b0;
        end else if (funct3 == F3_AND) begin
          alu_op_o = ALU_AND; use_imm_o = 1'b1; rd_we_o = 1'b1; illegal_o = 1'b0;
        end
      end
      OPC_LOAD: begin
        alu_op_o = ALU_ADD; use_imm_o = 1'b1; rd_we_o = 1'b1; illegal_o = 1'b0;
      end
      OPC_STORE: begin
        alu_op_o = ALU_ADD; use_imm_o = 1'b1; imm_o = imm_s; illegal_o = 1'b0;
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          alu_op_o = ALU_SUB; illegal_o = 1'b0;
        end
      end
      default: ;
    endcase
    // x0 is never written, so suppress the enable at the source.
    if (instr_i[11:7] == 5'd0) begin
      rd_we_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: resolves operands (with EX forwarding) and presents registered ALU inputs.
// Latency 1 cycle from accept to out_valid; a two-entry main+skid buffer absorbs one extra beat.
// in_ready is registered and drops only when both entries are full; outputs hold while stalled.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_we,
  input  logic [4:0]        ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  alu_issue_stage_if.slave  bus
);

  buf_state_e   state_q, state_d;
  issue_entry_t main_q, main_d;
  issue_entry_t skid_q, skid_d;
  logic         in_ready_q;

  logic [3:0]      dec_alu_op;
  logic            dec_use_imm;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rs1_addr;
  logic [4:0]      dec_rs2_addr;
  logic [4:0]      dec_rd;
  logic            dec_rd_we;
  logic            dec_illegal;

  logic            fwd_rs1;
  logic            fwd_rs2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  issue_entry_t    new_entry;
  logic            accept;
  logic            issue;

  alu_op_decoder #(.XLEN(XLEN)) u_dec (
    .instr_i    (bus.in_instr),
    .alu_op_o   (dec_alu_op),
    .use_imm_o  (dec_use_imm),
    .imm_o      (dec_imm),
    .rs1_addr_o (dec_rs1_addr),
    .rs2_addr_o (dec_rs2_addr),
    .rd_o       (dec_rd),
    .rd_we_o    (dec_rd_we),
    .illegal_o  (dec_illegal)
  );

  assign bus.rs1_addr = dec_rs1_addr;
  assign bus.rs2_addr = dec_rs2_addr;

  // EX is still writing its result this cycle, so a matching source takes the EX value (x0 excluded).
  assign fwd_rs1 = FWD_EN && ex_we && (ex_rd != 5'd0) && (ex_rd == dec_rs1_addr);
  assign fwd_rs2 = FWD_EN && ex_we && (ex_rd != 5'd0) && (ex_rd == dec_rs2_addr);
  assign rs1_val = fwd_rs1 ? ex_result : bus.rs1_data;
  assign rs2_val = fwd_rs2 ? ex_result : bus.rs2_data;

  assign accept = bus.in_valid && in_ready_q;
  assign issue  = (state_q != BUF_EMPTY) && bus.out_ready;

  // Assemble the entry the incoming instruction would occupy; illegal ones carry zero operands.
  always_comb begin
    new_entry         = ENTRY_RESET;
    new_entry.alu_op  = dec_alu_op;
    new_entry.rd      = dec_rd;
    new_entry.rd_we   = dec_rd_we;
    new_entry.illegal = dec_illegal;
    if (!dec_illegal) begin
      new_entry.op1 = rs1_val;
      new_entry.op2 = dec_use_imm ? dec_imm : rs2_val;
    end
  end

  // Buffer occupancy and entry movement; flush wins over any accept or issue in the same cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            main_d  = new_entry;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && issue) begin
            main_d = new_entry;
          end else if (accept) begin
            skid_d  = new_entry;
            state_d = BUF_TWO;
          end else if (issue) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (issue) begin
            main_d  = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // State and entry registers; in_ready is derived from the next state so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      main_q     <= ENTRY_RESET;
      skid_q     <= ENTRY_RESET;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != BUF_TWO);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != BUF_EMPTY);
  assign bus.ALUop     = main_q.alu_op;
  assign bus.op1       = main_q.op1;
  assign bus.op2       = main_q.op2;
  assign bus.rd        = main_q.rd;
  assign bus.rd_we     = main_q.rd_we;
  assign bus.illegal   = main_q.illegal;

endmodule
